// File: rtl/safecrack_keypad_arbiter.sv
// safecrack_keypad_arbiter
// Arbitrates two digit requesters (bit0 local keypad, bit1 remote console)
// onto a single ready/valid digit port toward the lock core. An owner keeps
// the port for one DIGITS-long sequence. It then loses the port for one gap
// cycle. It also loses the port after TIMEOUT_CYCLES-1 grant cycles in a row
// without a transfer.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid[1:0]    per-requester digit valid
//   req_digit0/1      per-requester digit (0..3)
//   req_ready[1:0]    per-requester accept (pass-through of core_ready for owner)
//   core_valid/digit  digit toward the lock core (pass-through from owner)
//   core_ready        lock core accepts a digit
//   grant[1:0]        one-hot current owner, 0 when no owner
//   busy_reject[1:0]  non-owner presenting valid while the port is owned
//   seq_done          pulse on the transfer of the DIGITS-th digit
//   timeout           pulse when ownership is revoked for inactivity
//
// Configuration macro: ARB_FIXED_PRIORITY_EN. When it is defined, requester 0
// wins every tie. When it is undefined, ties are broken round-robin.
module safecrack_keypad_arbiter #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_digit0,
  input  logic [1:0] req_digit1,
  output logic [1:0] req_ready,
  output logic       core_valid,
  output logic [1:0] core_digit,
  input  logic       core_ready,
  output logic [1:0] grant,
  output logic [1:0] busy_reject,
  output logic       seq_done,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] digit_cnt_q, digit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pick;
  logic [1:0]    owner_digit;
  logic          xfer;
`ifndef ARB_FIXED_PRIORITY_EN
  logic          last_owner_q, last_owner_d;
`endif

  // Winner of a new grant: a lone requester wins outright. On a tie, the
  // fixed-priority build picks requester 0. The round-robin build picks
  // the requester that did not own the port last.
  always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
    pick = !req_valid[0];
`else
    pick = (req_valid == 2'b11) ? !last_owner_q : req_valid[1];
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      digit_cnt_q  <= '0;
      timer_q      <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      digit_cnt_q  <= digit_cnt_d;
      timer_q      <= timer_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Next-state logic and the combinational outputs
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    digit_cnt_d  = digit_cnt_q;
    timer_d      = timer_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_owner_d = last_owner_q;
`endif
    req_ready    = '0;
    core_valid   = 1'b0;
    core_digit   = '0;
    grant        = '0;
    busy_reject  = '0;
    seq_done     = 1'b0;
    timeout      = 1'b0;
    xfer         = 1'b0;
    owner_digit  = owner_q ? req_digit1 : req_digit0;

    case (state_q)
      S_IDLE: begin
        timer_d     = '0;
        digit_cnt_d = '0;
        if (|req_valid) begin
          owner_d      = pick;
`ifndef ARB_FIXED_PRIORITY_EN
          last_owner_d = pick;
`endif
          state_d      = S_GRANT;
        end
      end

      S_GRANT: begin
        grant[owner_q]        = 1'b1;
        core_valid            = req_valid[owner_q];
        core_digit            = owner_digit;
        req_ready[owner_q]    = core_ready;
        busy_reject[!owner_q] = req_valid[!owner_q];
        xfer                  = req_valid[owner_q] && core_ready;
        if (xfer) begin
          // A transfer always clears the timer, even in the threshold cycle.
          timer_d = '0;
          if (digit_cnt_q == CW'(DIGITS - 1)) begin
            seq_done    = 1'b1;
            digit_cnt_d = '0;
            state_d     = S_GAP;
          end else begin
            digit_cnt_d = digit_cnt_q + CW'(1);
          end
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 2)) begin
          // This is the (TIMEOUT_CYCLES-1)-th idle grant cycle in a row.
          timeout     = 1'b1;
          digit_cnt_d = '0;
          timer_d     = '0;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs read as zero while reset is held, even from a stale state.
    if (rst) begin
      req_ready   = '0;
      core_valid  = 1'b0;
      core_digit  = '0;
      grant       = '0;
      busy_reject = '0;
      seq_done    = 1'b0;
      timeout     = 1'b0;
    end
  end

endmodule

// File: tb/tb_safecrack_keypad_arbiter.sv
// Testbench for safecrack_keypad_arbiter (DIGITS=3, TIMEOUT_CYCLES=16).
// Requesters behave as the interface demands: each holds valid and its digit
// until it is accepted. A transaction-level model of ownership predicts every
// output in every cycle.
module tb_safecrack_keypad_arbiter;

  localparam int DIGITS  = 3;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_digit0 = '0;
  logic [1:0] req_digit1 = '0;
  logic [1:0] req_ready;
  logic       core_valid;
  logic [1:0] core_digit;
  logic       core_ready = 1'b0;
  logic [1:0] grant;
  logic [1:0] busy_reject;
  logic       seq_done;
  logic       timeout;

  safecrack_keypad_arbiter #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_digit0(req_digit0),
    .req_digit1(req_digit1), .req_ready(req_ready), .core_valid(core_valid),
    .core_digit(core_digit), .core_ready(core_ready), .grant(grant),
    .busy_reject(busy_reject), .seq_done(seq_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // The model tracks who owns the port (-1 = nobody) and whether a gap cycle
  // is pending. It also counts the digits taken from the current owner and
  // the grant cycles since the last transfer. last_owner starts at 1.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_count = 0;
  int m_idle  = 0;
  int m_last  = 1;

  // Requester-side state: presenting a digit, and forced digits to present.
  bit       pres[2];
  int       cur[2];
  int       forced[2][$];
  int       n_sd_exp = 0, n_sd_obs = 0, n_to_exp = 0, n_to_obs = 0;

  task automatic step(input bit r, input int p0, input int p1, input int pcr);
    int pp[2];
    int e_grant, e_rr, e_br, e_cv, e_cd, e_sd, e_to;
    bit cr, xfer;
    int o;
    pp[0] = p0;
    pp[1] = p1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!pres[i]) begin
        cur[i] = int'($urandom_range(3));
        if (int'($urandom_range(99)) < pp[i]) begin
          pres[i] = 1'b1;
          if (forced[i].size() > 0) cur[i] = forced[i].pop_front();
        end
      end
    end
    cr         = int'($urandom_range(99)) < pcr;
    rst        = r;
    req_valid  = {pres[1], pres[0]};
    req_digit0 = 2'(cur[0]);
    req_digit1 = 2'(cur[1]);
    core_ready = cr;
    #1;

    e_grant = 0; e_rr = 0; e_br = 0; e_cv = 0; e_cd = 0; e_sd = 0; e_to = 0;
    xfer = 1'b0;
    o = m_owner;
    if (!r && o >= 0) begin
      e_grant = 1 << o;
      e_cv    = int'(pres[o]);
      e_cd    = cur[o];
      e_rr    = int'(cr) << o;
      e_br    = int'(pres[1-o]) << (1 - o);
      xfer    = pres[o] && cr;
      if (xfer && m_count + 1 == DIGITS) e_sd = 1;
      if (!xfer && m_idle + 1 == TIMEOUT - 1) e_to = 1;
    end

    check("grant", int'(grant), e_grant);
    check("req_ready", int'(req_ready), e_rr);
    check("core_valid", int'(core_valid), e_cv);
    check("core_digit", int'(core_digit), e_cd);
    check("busy_reject", int'(busy_reject), e_br);
    check("seq_done", int'(seq_done), e_sd);
    check("timeout", int'(timeout), e_to);
    n_sd_exp += e_sd; n_sd_obs += int'(seq_done);
    n_to_exp += e_to; n_to_obs += int'(timeout);

    // Advance the model by one clock edge.
    if (r) begin
      m_owner = -1; m_gap = 1'b0; m_count = 0; m_idle = 0; m_last = 1;
      pres[0] = 1'b0; pres[1] = 1'b0;
    end else if (o >= 0) begin
      if (xfer) begin
        pres[o] = 1'b0;
        m_idle  = 0;
        m_count++;
        if (m_count == DIGITS) begin
          m_count = 0; m_owner = -1; m_gap = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT - 1) begin
          m_owner = -1; m_count = 0; m_idle = 0;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (pres[0] || pres[1]) begin
      if (pres[0] && pres[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
        m_owner = 0;
`else
        m_owner = 1 - m_last;
`endif
      end else begin
        m_owner = pres[1] ? 1 : 0;
      end
      m_last  = m_owner;
      m_idle  = 0;
      m_count = 0;
    end
  endtask

  initial begin
    int pv0, pv1, pcr;
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // Requester 0 sends 2,1,3 with the core always ready
    forced[0].push_back(2); forced[0].push_back(1); forced[0].push_back(3);
    repeat (6) step(0, 100, 0, 100);
    repeat (3) step(0, 0, 0, 100);

    // Simultaneous requests, twice in a row
    step(1, 0, 0, 0);
    repeat (14) step(0, 100, 100, 100);

    // Requester 1 blocked while requester 0 owns the port, slow core
    step(1, 0, 0, 0);
    repeat (20) step(0, 100, 100, 30);

    // One transfer, then silence until the timeout, then a new sequence
    step(1, 0, 0, 0);
    repeat (2) step(0, 100, 0, 100);
    repeat (18) step(0, 0, 0, 100);
    repeat (8) step(0, 0, 100, 100);

    // Core stalled while the owner waits; the transfer lands near threshold
    step(1, 0, 0, 0);
    repeat (15) step(0, 100, 0, 0);
    repeat (4) step(0, 100, 0, 100);

    // Reset after the second digit, then a fresh sequence
    step(1, 0, 0, 0);
    repeat (3) step(0, 100, 0, 100);
    step(1, 0, 0, 0);
    repeat (8) step(0, 100, 0, 100);

    // Randomized traffic with varying pressure and occasional resets
    pv0 = 50; pv1 = 50; pcr = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        pv0 = int'($urandom_range(2)) * 45 + 5;
        pv1 = int'($urandom_range(2)) * 45 + 5;
        pcr = int'($urandom_range(3)) * 30 + 10;
      end
      step($urandom_range(499) == 0, pv0, pv1, pcr);
    end

    check("seq_done_count", n_sd_obs, n_sd_exp);
    check("timeout_count", n_to_obs, n_to_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
